// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the RGB PWM generator.
// Imported by the channel slice and the top-level timing logic.
package pwm_pkg;

  localparam int unsigned DUTY_W           = 8;
  localparam int unsigned DEFAULT_PRESCALE = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  // Counter tops out one below full scale so duty 255 stays on for the whole period.
  localparam duty_t PWM_MAX = 8'd254;

  function automatic logic inactive_level(input bit active_high);
    return ~active_high;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, unsigned compare against the shared
// period counter, and the registered output pin.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  run,
  input  logic  load,
  input  duty_t duty,
  input  duty_t pwm_cnt,
  output logic  pwm
);

  duty_t r_shadow;
  logic  r_pwm;
  logic  w_active;

  assign w_active = (pwm_cnt < r_shadow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_pwm    <= inactive_level(ACTIVE_HIGH);
    end else begin
      if (load) begin
        r_shadow <= duty;
      end
      if (!run) begin
        r_pwm <= inactive_level(ACTIVE_HIGH);
      end else begin
        r_pwm <= ACTIVE_HIGH ? w_active : ~w_active;
      end
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_generator.sv
// Three-channel PWM driver for an RGB LED. Owns the prescaler, the shared
// period counter and the wrap/load timing; duties only take effect at wraps.
module rgb_pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE    = DEFAULT_PRESCALE,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DUTY_W-1:0] r_duty,
  input  logic [DUTY_W-1:0] g_duty,
  input  logic [DUTY_W-1:0] b_duty,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic              period_start
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  duty_t            r_pwm_cnt;
  logic             r_period_start;

  logic w_tick;
  logic w_wrap;
  logic w_load;

  assign w_tick = enable && (r_pre_cnt == PRE_LAST);
  assign w_wrap = w_tick && (r_pwm_cnt == PWM_MAX);
  // While idle the shadows track the inputs so the first period after enable
  // starts with the duties present just before it.
  assign w_load = w_wrap || !enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt      <= '0;
      r_pwm_cnt      <= '0;
      r_period_start <= 1'b0;
    end else if (!enable) begin
      r_pre_cnt      <= '0;
      r_pwm_cnt      <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_wrap;
      if (w_tick) begin
        r_pre_cnt <= '0;
        r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + 8'd1;
      end else begin
        r_pre_cnt <= r_pre_cnt + PRE_W'(1);
      end
    end
  end

  pwm_channel #(
    .ACTIVE_HIGH(ACTIVE_HIGH)
  ) u_ch_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (enable),
    .load   (w_load),
    .duty   (r_duty),
    .pwm_cnt(r_pwm_cnt),
    .pwm    (pwm_r)
  );

  pwm_channel #(
    .ACTIVE_HIGH(ACTIVE_HIGH)
  ) u_ch_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (enable),
    .load   (w_load),
    .duty   (g_duty),
    .pwm_cnt(r_pwm_cnt),
    .pwm    (pwm_g)
  );

  pwm_channel #(
    .ACTIVE_HIGH(ACTIVE_HIGH)
  ) u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (enable),
    .load   (w_load),
    .duty   (b_duty),
    .pwm_cnt(r_pwm_cnt),
    .pwm    (pwm_b)
  );

  assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_pwm_generator.sv
// Bench for rgb_pwm_generator: an active-high and an active-low instance share
// stimulus; each period is checked for on-time = duty * PRESCALE clks.
module tb_rgb_pwm_generator;

  localparam int P   = 2;
  localparam int PER = 255 * P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] r_duty, g_duty, b_duty;
  logic       pr_h, pg_h, pb_h, ps_h;
  logic       pr_l, pg_l, pb_l, ps_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Duties in force for the period currently on the pins.
  logic [7:0] cur [3];
  int         m_hi [3];
  int         m_lo [3];
  bit         m_ok;

  always #5 clk = ~clk;

  rgb_pwm_generator #(
    .PRESCALE   (P),
    .ACTIVE_HIGH(1'b1)
  ) dut_h (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .r_duty      (r_duty),
    .g_duty      (g_duty),
    .b_duty      (b_duty),
    .pwm_r       (pr_h),
    .pwm_g       (pg_h),
    .pwm_b       (pb_h),
    .period_start(ps_h)
  );

  rgb_pwm_generator #(
    .PRESCALE   (P),
    .ACTIVE_HIGH(1'b0)
  ) dut_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .r_duty      (r_duty),
    .g_duty      (g_duty),
    .b_duty      (b_duty),
    .pwm_r       (pr_l),
    .pwm_g       (pg_l),
    .pwm_b       (pb_l),
    .period_start(ps_l)
  );

  function automatic logic [7:0] rnd_duty();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd255;
      2:       return 8'd254;
      3:       return 8'd1;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Observe one whole period (PER samples); the last sample must carry the
  // next period_start. New duties are applied at sample chg_at.
  task automatic measure(input logic [7:0] nr, input logic [7:0] ng, input logic [7:0] nb,
                         input int chg_at);
    logic [2:0] vh, vl;
    for (int c = 0; c < 3; c++) begin
      m_hi[c] = 0;
      m_lo[c] = 0;
    end
    m_ok = 1'b1;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        r_duty = nr;
        g_duty = ng;
        b_duty = nb;
      end
      vh = {pb_h, pg_h, pr_h};
      vl = {pb_l, pg_l, pr_l};
      if ($isunknown({vh, vl, ps_h, ps_l})) m_ok = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (vh[c] === 1'b1) m_hi[c]++;
        if (vl[c] === 1'b0) m_lo[c]++;
      end
      if (i < PER - 1) begin
        if (ps_h !== 1'b0 || ps_l !== 1'b0) m_ok = 1'b0;
      end else begin
        if (ps_h !== 1'b1 || ps_l !== 1'b1) m_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    enable = 1'b0;
    r_duty = 8'd0;
    g_duty = 8'd0;
    b_duty = 8'd0;
    rst_n  = 1'b0;
    #1;
    n_tests++;
    if ({pr_h, pg_h, pb_h, ps_h} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async_hi got %b want 0000", {pr_h, pg_h, pb_h, ps_h});
    end
    n_tests++;
    if ({pr_l, pg_l, pb_l, ps_l} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_async_lo got %b want 1110", {pr_l, pg_l, pb_l, ps_l});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({pr_h, pg_h, pb_h, ps_h, pr_l, pg_l, pb_l, ps_l} !== 8'b0000_1110) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b want 00001110",
               {pr_h, pg_h, pb_h, ps_h, pr_l, pg_l, pb_l, ps_l});
    end
  endtask

  // Fixed 0/255/128 from enable, then random duties swapped mid-period.
  task automatic test_patterns;
    logic [7:0] nxt [3];
    r_duty = 8'd0;
    g_duty = 8'd255;
    b_duty = 8'd128;
    cur[0] = 8'd0;
    cur[1] = 8'd255;
    cur[2] = 8'd128;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 3; c++) nxt[c] = (k == 0) ? cur[c] : rnd_duty();
      measure(nxt[0], nxt[1], nxt[2], (k == 0) ? -1 : int'($urandom_range(0, PER - 3)));
      n_tests++;
      if (!m_ok) begin
        n_fail++;
        $display("FAIL patterns_period_start k=%0d got irregular want one pulse per %0d", k, PER);
      end
      for (int c = 0; c < 3; c++) begin
        n_tests += 2;
        if (m_hi[c] != int'(cur[c]) * P) begin
          n_fail++;
          $display("FAIL patterns_hi k=%0d ch%0d got %0d want %0d", k, c, m_hi[c],
                   int'(cur[c]) * P);
        end
        if (m_lo[c] != int'(cur[c]) * P) begin
          n_fail++;
          $display("FAIL patterns_lo k=%0d ch%0d got %0d want %0d", k, c, m_lo[c],
                   int'(cur[c]) * P);
        end
      end
      for (int c = 0; c < 3; c++) cur[c] = nxt[c];
    end
  endtask

  // Red 64 -> 192 around pwm_cnt=100: old period keeps 64, next gets 192.
  task automatic test_mid_change;
    logic [7:0] want [3];
    measure(8'd64, cur[1], cur[2], 3);
    want[0] = 8'd64;
    want[1] = cur[1];
    want[2] = cur[2];
    cur[0]  = 8'd64;
    measure(8'd192, cur[1], cur[2], 200);
    n_tests++;
    if (m_hi[0] != 64 * P || !m_ok) begin
      n_fail++;
      $display("FAIL mid_change_old got %0d ok=%0d want %0d ok=1", m_hi[0], m_ok, 64 * P);
    end
    measure(8'd192, want[1], want[2], -1);
    n_tests++;
    if (m_hi[0] != 192 * P || m_lo[0] != 192 * P || !m_ok) begin
      n_fail++;
      $display("FAIL mid_change_new got %0d/%0d ok=%0d want %0d", m_hi[0], m_lo[0], m_ok,
               192 * P);
    end
    cur[0] = 8'd192;
  endtask

  task automatic test_enable_drop;
    logic [7:0] g, b;
    g = rnd_duty();
    b = rnd_duty();
    repeat (100) @(negedge clk);
    enable = 1'b0;
    r_duty = 8'd10;
    g_duty = g;
    b_duty = b;
    @(negedge clk);
    n_tests++;
    if ({pr_h, pg_h, pb_h, ps_h, pr_l, pg_l, pb_l, ps_l} !== 8'b0000_1110) begin
      n_fail++;
      $display("FAIL enable_drop_outputs got %b want 00001110",
               {pr_h, pg_h, pb_h, ps_h, pr_l, pg_l, pb_l, ps_l});
    end
    n_tests++;
    if (dut_h.r_pwm_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL enable_drop_cnt got %0d want 0", dut_h.r_pwm_cnt);
    end
    repeat (3) @(negedge clk);
    enable = 1'b1;
    measure(8'd10, g, b, -1);
    n_tests++;
    if (m_hi[0] != 10 * P || m_lo[0] != 10 * P || !m_ok) begin
      n_fail++;
      $display("FAIL reenable_first got %0d/%0d ok=%0d want %0d", m_hi[0], m_lo[0], m_ok,
               10 * P);
    end
    n_tests++;
    if (m_hi[1] != int'(g) * P || m_hi[2] != int'(b) * P) begin
      n_fail++;
      $display("FAIL reenable_gb got %0d,%0d want %0d,%0d", m_hi[1], m_hi[2], int'(g) * P,
               int'(b) * P);
    end
    cur[0] = 8'd10;
    cur[1] = g;
    cur[2] = b;
  endtask

  // Enable falls on exactly the wrap clk: no period_start, counters cleared.
  task automatic test_wrap_vs_enable;
    logic [7:0] nd [3];
    for (int i = 0; i < PER - 1; i++) begin
      @(negedge clk);
      if (i == PER - 2) enable = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (ps_h !== 1'b0 || ps_l !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_vs_enable_ps got %b%b want 00", ps_h, ps_l);
    end
    n_tests++;
    if ({pr_h, pg_h, pb_h, pr_l, pg_l, pb_l} !== 6'b000_111 || dut_h.r_pwm_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_vs_enable_idle got %b cnt=%0d want 000111 cnt=0",
               {pr_h, pg_h, pb_h, pr_l, pg_l, pb_l}, dut_h.r_pwm_cnt);
    end
    for (int c = 0; c < 3; c++) nd[c] = rnd_duty();
    r_duty = nd[0];
    g_duty = nd[1];
    b_duty = nd[2];
    repeat (2) @(negedge clk);
    enable = 1'b1;
    measure(nd[0], nd[1], nd[2], -1);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (m_hi[c] != int'(nd[c]) * P || !m_ok) begin
        n_fail++;
        $display("FAIL wrap_restart ch%0d got %0d ok=%0d want %0d", c, m_hi[c], m_ok,
                 int'(nd[c]) * P);
      end
    end
    for (int c = 0; c < 3; c++) cur[c] = nd[c];
  endtask

  task automatic test_reset_mid;
    logic [7:0] nd [3];
    measure(cur[0], cur[1], 8'd200, 5);
    cur[2] = 8'd200;
    repeat (50) @(negedge clk);
    n_tests++;
    if (pb_h !== 1'b1 || pb_l !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pre got %b%b want 10", pb_h, pb_l);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pb_h !== 1'b0 || pb_l !== 1'b1 || ps_h !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got %b%b%b want 010", pb_h, pb_l, ps_h);
    end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) nd[c] = rnd_duty();
    r_duty = nd[0];
    g_duty = nd[1];
    b_duty = nd[2];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    measure(nd[0], nd[1], nd[2], -1);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (m_hi[c] != int'(nd[c]) * P || m_lo[c] != int'(nd[c]) * P || !m_ok) begin
        n_fail++;
        $display("FAIL reset_mid_after ch%0d got %0d/%0d ok=%0d want %0d", c, m_hi[c],
                 m_lo[c], m_ok, int'(nd[c]) * P);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    r_duty = 8'd0;
    g_duty = 8'd0;
    b_duty = 8'd0;
    #2;
    test_reset();
    test_patterns();
    test_mid_change();
    test_enable_drop();
    test_wrap_vs_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
